addr_fifo: RTL
==============

Name: addr_fifo

Overview:
Synchronous address FIFO that sits directly downstream of the driver. It accepts 32-bit test-vector addresses written by the driver and hands them to the vector fetch logic on read requests. It reports occupancy, full/empty, almost-full against a driver-programmed threshold, and sticky overrun/underrun errors, all of which feed back to the driver's status and monitor logic.

Parameters:
DATA_WIDTH, 32, width of each stored address word
DEPTH, 256, number of entries; must be a power of 2 and at most 2^CNT_WIDTH-1
CNT_WIDTH, 16, width of the occupancy and threshold fields

Ports:
clk  input  1  single clock; all logic is on the rising edge
reset  input  1  synchronous, active-high reset
addr_fifo_din  input  DATA_WIDTH  write data from the driver
addr_fifo_wr  input  1  write request
addr_fifo_rd  input  1  read request from the fetch stage
addr_fifo_dout  output  DATA_WIDTH  read data, registered
addr_fifo_dout_val  output  1  one-cycle pulse; addr_fifo_dout is valid in this cycle
addr_fifo_threshold  input  CNT_WIDTH  almost-full level, programmed by the driver
err_clr  input  1  clears the sticky error flags
addr_fifo_full  output  1  occupancy == DEPTH
addr_fifo_empty  output  1  occupancy == 0
addr_fifo_almost_full  output  1  occupancy >= threshold, with threshold != 0
addr_fifo_overrun  output  1  sticky: a write was attempted while full
addr_fifo_underrun  output  1  sticky: a read was attempted while empty
words_in_addr_fifo  output  CNT_WIDTH  current occupancy

Behaviour:
- Reset (synchronous, active-high; clk and reset as named above):
  - wr_ptr = rd_ptr = 0 and count = 0.
  - addr_fifo_dout = 0, addr_fifo_dout_val = 0.
  - full = 0, empty = 1, almost_full = 0, overrun = 0, underrun = 0, words_in_addr_fifo = 0.
  - Storage contents are not reset.
  - Reset asserted mid-operation discards all entries on that edge. Any wr, rd or err_clr in the same cycle is ignored.
- Pointers: log2(DEPTH) bits each; they wrap naturally from DEPTH-1 to 0. Occupancy comes from a separate count register (CNT_WIDTH bits), not from pointer difference.
- Accepted write: wr_acc = addr_fifo_wr & (~full | rd_acc).
  - mem[wr_ptr] <= din and wr_ptr increments.
- Accepted read: rd_acc = addr_fifo_rd & ~empty.
  - addr_fifo_dout <= mem[rd_ptr] and rd_ptr increments.
  - addr_fifo_dout_val = 1 in the following cycle, giving 1-cycle read latency.
  - addr_fifo_dout holds its last value when no read is accepted.
- Count update:
  - +1 on wr_acc & ~rd_acc.
  - -1 on rd_acc & ~wr_acc.
  - Unchanged when both or neither occur.
- Simultaneous read and write:
  - When full: both are accepted, count stays at DEPTH, no overrun.
  - When empty: the write is accepted, the read is rejected and sets underrun. There is no write-through; the new word is readable from the next cycle.
  - In the general case both complete in the same cycle.
- Rejected write (wr while full, no read accepted): data is dropped, pointers and count are unchanged, overrun <= 1.
- Rejected read (rd while empty): rd_ptr is unchanged, dout_val stays 0, underrun <= 1.
- Status timing: full, empty, almost_full and words_in_addr_fifo are registered. They reflect the count after the current edge and update together with count.
- almost_full is compared against the live threshold input every cycle. threshold = 0 disables it (forced 0).
- Sticky errors: cleared by err_clr. If err_clr and a new error occur in the same cycle, the error wins and the flag stays 1.
- Storage is inferable as simple dual-port block RAM with a registered read and no combinational read path.

Test Plan:
- Basic order, DEPTH=16. Write 0x1000..0x1003 on 4 consecutive cycles, then read 4 times → dout 0x1000,0x1001,0x1002,0x1003, each with dout_val one cycle after its rd; count 4→0; empty=1 at the end.
- Fill and overrun. Write 16 words → full=1, count=16. A 17th write of 0xDEAD → overrun=1, count stays 16. Reading all 16 back never returns 0xDEAD.
- Underrun and clear. Read while empty → underrun=1, dout_val=0. Pulse err_clr → underrun=0. Read while empty together with err_clr → underrun=1.
- Simultaneous operations:
  - Full plus rd and wr of 0xBEEF → count stays 16, no overrun; 0xBEEF is read out 16th.
  - Empty plus rd and wr → count=1 and underrun=1.
- Wrap and threshold. Run 40 interleaved write/read pairs through DEPTH=16 → data order preserved across pointer wrap. With threshold=10, almost_full asserts on the edge count reaches 10 and deasserts at 9; threshold=0 → never asserted.
- Reset mid-operation. With count=7, assert reset in the same cycle as a write → count=0, empty=1, flags 0. The next write/read returns only the new data.

Source files
------------

// File: rtl/addr_fifo_if.sv
// addr_fifo_if: driver-side write/read/status bundle for the address FIFO
interface addr_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] addr_fifo_din;
    logic                  addr_fifo_wr;
    logic                  addr_fifo_rd;
    logic [DATA_WIDTH-1:0] addr_fifo_dout;
    logic                  addr_fifo_dout_val;
    logic [CNT_WIDTH-1:0]  addr_fifo_threshold;
    logic                  err_clr;
    logic                  addr_fifo_full;
    logic                  addr_fifo_empty;
    logic                  addr_fifo_almost_full;
    logic                  addr_fifo_overrun;
    logic                  addr_fifo_underrun;
    logic [CNT_WIDTH-1:0]  words_in_addr_fifo;

    modport master (
        output addr_fifo_din, addr_fifo_wr, addr_fifo_rd, addr_fifo_threshold, err_clr,
        input  addr_fifo_dout, addr_fifo_dout_val, addr_fifo_full, addr_fifo_empty,
               addr_fifo_almost_full, addr_fifo_overrun, addr_fifo_underrun, words_in_addr_fifo
    );

    modport slave (
        input  addr_fifo_din, addr_fifo_wr, addr_fifo_rd, addr_fifo_threshold, err_clr,
        output addr_fifo_dout, addr_fifo_dout_val, addr_fifo_full, addr_fifo_empty,
               addr_fifo_almost_full, addr_fifo_overrun, addr_fifo_underrun, words_in_addr_fifo
    );
endinterface

// File: rtl/addr_fifo.sv
// addr_fifo: synchronous address FIFO with registered status and sticky errors
module addr_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int CNT_WIDTH  = 16
) (
    input logic        clk,
    input logic        reset,
    addr_fifo_if.slave f
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CNT_WIDTH-1:0]  count, count_nxt;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_val, full, empty, almost_full, overrun, underrun;
    logic                  wr_acc, rd_acc, wr_rej, rd_rej;

    always_comb begin
        rd_acc    = f.addr_fifo_rd & ~empty;
        wr_acc    = f.addr_fifo_wr & (~full | rd_acc);
        wr_rej    = f.addr_fifo_wr & ~wr_acc;
        rd_rej    = f.addr_fifo_rd & empty;
        count_nxt = (wr_acc & ~rd_acc) ? count + CNT_WIDTH'(1) :
                    (rd_acc & ~wr_acc) ? count - CNT_WIDTH'(1) : count;
    end

    // storage kept free of reset so it maps onto block RAM
    always_ff @(posedge clk)
        if (wr_acc && !reset)
            mem[wr_ptr] <= f.addr_fifo_din;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            dout        <= '0;
            dout_val    <= 1'b0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= 1'b0;
            overrun     <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
                dout   <= mem[rd_ptr];
            end
            dout_val    <= rd_acc;
            count       <= count_nxt;
            full        <= count_nxt == CNT_WIDTH'(DEPTH);
            empty       <= count_nxt == '0;
            almost_full <= (f.addr_fifo_threshold != '0) && (count_nxt >= f.addr_fifo_threshold);
            overrun     <= wr_rej | (overrun & ~f.err_clr);
            underrun    <= rd_rej | (underrun & ~f.err_clr);
        end
    end

    assign f.addr_fifo_dout        = dout;
    assign f.addr_fifo_dout_val    = dout_val;
    assign f.addr_fifo_full        = full;
    assign f.addr_fifo_empty       = empty;
    assign f.addr_fifo_almost_full = almost_full;
    assign f.addr_fifo_overrun     = overrun;
    assign f.addr_fifo_underrun    = underrun;
    assign f.words_in_addr_fifo    = count;
endmodule
